spi_master_ctrl: RTL and testbench

- Initiator-side SPI engine that drives the single-clock SPI slave protocol: SS_n, MOSI and MISO, with serial data changing on clk.
- Accepts one 2-bit command plus an 8-bit payload per request through a valid/ready host port and serialises it as one framed transfer.
- For read-data commands, captures the slave's 8-bit reply from MISO and returns it on a response port.
- Sits between the host bus logic and the SPI pins, as the counterpart of the slave FSM (IDLE/CHK_CMD/WRITE/READ_ADD/READ_DATA).

---
 rtl/spi_master_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI initiator: one {cmd,data} request per frame on SS_n/MOSI, rd-data frames capture a MISO byte.
// Optional `define SPI_MASTER_RDADDR_TRACK_EN rejects rd-data requests not preceded by an rd-addr frame.
module spi_master_ctrl #(
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       done,
  output logic       seq_err
);

  typedef enum logic [2:0] {IDLE, SEL, MODE, SHIFT, WAITL, RECV, GAP, ERR} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [9:0] shift_q;
  logic [1:0] cmd_q;
  logic [7:0] rx_q;
  logic       accept;
  logic       seq_fault;
  logic       ss_n_nxt, mosi_nxt, done_nxt, rsp_valid_nxt, seq_err_nxt;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef SPI_MASTER_RDADDR_TRACK_EN
  logic rd_addr_seen;

  assign seq_fault = (req_cmd == 2'b11) && !rd_addr_seen;

  // Completion of a frame is its entry into GAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr_seen <= 1'b0;
    end else if (state_nxt == GAP && state != GAP) begin
      if (cmd_q == 2'b10)
        rd_addr_seen <= 1'b1;
      else if (cmd_q == 2'b11)
        rd_addr_seen <= 1'b0;
    end
  end
`else
  assign seq_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:    if (accept) state_nxt = seq_fault ? ERR : SEL;
      SEL:     state_nxt = MODE;
      MODE:    state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd0) state_nxt = (cmd_q == 2'b11) ? WAITL : GAP;
      WAITL:   if (cnt == 4'd0) state_nxt = RECV;
      RECV:    if (cnt == 4'd0) state_nxt = GAP;
      GAP:     if (cnt == 4'd0) state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Down-counter is reloaded with (length-1) whenever a state is entered.
    if (state_nxt != state) begin
      case (state_nxt)
        SHIFT:   cnt_nxt = 4'd9;
        WAITL:   cnt_nxt = WAIT_LAST;
        RECV:    cnt_nxt = 4'd7;
        GAP:     cnt_nxt = GAP_LAST;
        default: cnt_nxt = 4'd0;
      endcase
    end else if (cnt != 4'd0) begin
      cnt_nxt = cnt - 4'd1;
    end
  end

  // Pin values for the coming cycle, decoded from the state being entered.
  always_comb begin
    ss_n_nxt      = 1'b1;
    mosi_nxt      = 1'b0;
    done_nxt      = 1'b0;
    rsp_valid_nxt = 1'b0;
    seq_err_nxt   = 1'b0;
    case (state_nxt)
      SEL, WAITL, RECV: ss_n_nxt = 1'b0;
      MODE, SHIFT: begin
        ss_n_nxt = 1'b0;
        mosi_nxt = shift_q[9];
      end
      GAP: begin
        done_nxt      = (state != GAP);
        rsp_valid_nxt = (state == RECV);
      end
      ERR: begin
        done_nxt    = 1'b1;
        seq_err_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      done      <= 1'b0;
      rsp_valid <= 1'b0;
      seq_err   <= 1'b0;
      rsp_data  <= 8'h00;
      shift_q   <= 10'd0;
      cmd_q     <= 2'b00;
      rx_q      <= 8'h00;
    end else begin
      cnt       <= cnt_nxt;
      SS_n      <= ss_n_nxt;
      MOSI      <= mosi_nxt;
      done      <= done_nxt;
      rsp_valid <= rsp_valid_nxt;
      seq_err   <= seq_err_nxt;
      if (accept) begin
        shift_q <= {req_cmd, req_data};
        cmd_q   <= req_cmd;
      end else if (state_nxt == SHIFT) begin
        shift_q <= {shift_q[8:0], 1'b0};
      end
      if (state == RECV)
        rx_q <= {rx_q[6:0], MISO};
      if (state == RECV && state_nxt == GAP)
        rsp_data <= {rx_q[6:0], MISO};
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: per-frame expected pin trace built from frame rules, checked every cycle.
module tb_spi_master_ctrl;
  localparam int RDL = 2;
  localparam int G   = 1;

  logic       clk, rst_n, req_valid, req_ready, SS_n, MOSI, MISO, rsp_valid, done, seq_err;
  logic [1:0] req_cmd;
  logic [7:0] req_data, rsp_data;

  spi_master_ctrl #(.RD_LATENCY(RDL), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_data(req_data), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ss_n;
    logic       mosi;
    logic       done;
    logic       rsp_valid;
    logic       rdy;
    logic       seq_err;
    logic       miso;
    logic [7:0] rsp;
    logic [1:0] seen_op;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   errors = 0, checks = 0;
  int   cyc = 0, since = 0, acc_cnt = 0, acc_cyc = 0;
  logic started = 1'b0;
  logic seen = 1'b0;
  logic [7:0] exp_rsp = 8'h00;
  logic [7:0] slave_byte = 8'h00;

  // Monitor statistics gathered from the pins
  int   ss_run = 0, last_ss_low = 0, frames = 0, done_lat = 0;
  int   done_cnt = 0, rsp_cnt = 0, seqerr_cnt = 0;
  logic [31:0] mosi_hist = 0, last_mosi = 0, prev_mosi = 0;

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.ss_n = 1'b1;
    e.rdy  = 1'b1;
    e.miso = 1'($urandom);
    return e;
  endfunction

  task automatic build(input logic [1:0] c, input logic [7:0] d);
    exp_t e;
    logic [9:0] bits;
    int len;
    logic err_frame;
    bits = {c, d};
    err_frame = 1'b0;
`ifdef SPI_MASTER_RDADDR_TRACK_EN
    err_frame = (c == 2'b11) && !seen;
`endif
    if (err_frame) begin
      e = '0;
      e.ss_n = 1'b1; e.done = 1'b1; e.seq_err = 1'b1; e.miso = 1'($urandom);
      q.push_back(e);
    end else begin
      len = (c == 2'b11) ? 20 + RDL : 12;
      for (int i = 1; i <= len + G; i++) begin
        e = '0;
        e.miso = 1'($urandom);
        e.ss_n = (i > len);
        if (i == 2) e.mosi = c[1];
        else if (i >= 3 && i <= 12) e.mosi = bits[12 - i];
        if (c == 2'b11 && i >= 13 + RDL && i <= 20 + RDL) e.miso = slave_byte[20 + RDL - i];
        if (i == len + 1) begin
          e.done = 1'b1;
          if (c == 2'b11) begin
            e.rsp_valid = 1'b1; e.rsp = slave_byte; e.seen_op = 2'd2;
          end else if (c == 2'b10) begin
            e.seen_op = 2'd1;
          end
        end
        q.push_back(e);
      end
    end
  endtask

  // Model: advances one expected cycle per clock edge.
  always @(posedge clk) begin
    cyc++;
    since++;
    started = 1'b1;
    if (!rst_n) begin
      q.delete();
      cur = idle_e();
      exp_rsp = 8'h00;
      seen = 1'b0;
    end else begin
      if (req_valid && cur.rdy) begin
        build(req_cmd, req_data);
        acc_cnt++;
        acc_cyc = cyc;
        since = 1;
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = idle_e();
      if (cur.rsp_valid) exp_rsp = cur.rsp;
      if (cur.seen_op == 2'd1) seen = 1'b1;
      else if (cur.seen_op == 2'd2) seen = 1'b0;
    end
  end

  // Compare + monitor, away from the active edge; also drives the slave MISO.
  always @(negedge clk) begin
    logic [5:0] act, expv;
    if (started) begin
      act  = {SS_n, MOSI, done, rsp_valid, req_ready, seq_err};
      expv = {cur.ss_n, cur.mosi, cur.done, cur.rsp_valid, cur.rdy, cur.seq_err};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t ss_n,mosi,done,rsp_valid,req_ready,seq_err got %b required %b", $time, act, expv);
      end
      checks++;
      if (rsp_data !== exp_rsp) begin
        errors++;
        $display("FAIL rsp_data_hold t=%0t got %h required %h", $time, rsp_data, exp_rsp);
      end
      if (!SS_n) begin
        if (ss_run == 0) mosi_hist = 0;
        ss_run++;
        mosi_hist = {mosi_hist[30:0], MOSI};
      end else if (ss_run > 0) begin
        last_ss_low = ss_run;
        ss_run = 0;
        frames++;
        prev_mosi = last_mosi;
        last_mosi = mosi_hist;
      end
      if (done) begin done_cnt++; done_lat = since; end
      if (rsp_valid) rsp_cnt++;
      if (seq_err) seqerr_cnt++;
      MISO = cur.miso;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic wait_acc(input int target);
    int t;
    t = 0;
    while (acc_cnt < target && t < 200) begin @(negedge clk); t++; end
    if (acc_cnt < target) begin
      errors++;
      $display("FAIL accept_timeout got %0d accepts required %0d", acc_cnt, target);
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] d);
    int n0;
    n0 = acc_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = c; req_data = d;
    wait_acc(n0 + 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(q.size() == 0 && cur.rdy) && t < 200) begin @(negedge clk); t++; end
    if (!(q.size() == 0 && cur.rdy)) begin
      errors++;
      $display("FAIL idle_timeout got busy after %0d cycles required idle", t);
    end
  endtask

  initial begin
    int r0, s0, f0, n0, a1, a2, d0;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 2'b00; req_data = 8'h00; MISO = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pins", int'({SS_n, MOSI, req_ready, done, rsp_valid, seq_err}), int'(6'b101000));
    chk("reset_rsp_data", int'(rsp_data), 0);
    rst_n = 1'b1;

    // rd-data straight after reset
    slave_byte = 8'h3E;
    issue(2'b11, 8'h00);
    wait_idle();
`ifdef SPI_MASTER_RDADDR_TRACK_EN
    chk("seqerr_count", seqerr_cnt, 1);
    chk("seqerr_done_lat", done_lat, 1);
    chk("seqerr_no_frame", frames, 0);
    chk("seqerr_no_rsp", rsp_cnt, 0);
`else
    chk("rd0_ss_low", last_ss_low, 22);
    chk("rd0_rsp_data", int'(rsp_data), 8'h3E);
    chk("rd0_seqerr", seqerr_cnt, 0);
`endif

    // write address 0x3C
    r0 = rsp_cnt;
    issue(2'b00, 8'h3C);
    wait_idle();
    chk("wa_ss_low", last_ss_low, 12);
    chk("wa_done_lat", done_lat, 13);
    chk("wa_mosi", int'(last_mosi[10:0]), int'(11'b00000111100));
    chk("wa_no_rsp", rsp_cnt, r0);

    // rd-addr 0x10 then rd-data returning 0xA5
    issue(2'b10, 8'h10);
    wait_idle();
    chk("ra_ss_low", last_ss_low, 12);
    chk("ra_mosi", int'(last_mosi[11:0]), 12'h610);
    r0 = rsp_cnt; s0 = seqerr_cnt;
    slave_byte = 8'hA5;
    issue(2'b11, 8'h00);
    wait_idle();
    chk("rd_rsp_data", int'(rsp_data), 8'hA5);
    chk("rd_rsp_once", rsp_cnt, r0 + 1);
    chk("rd_ss_low", last_ss_low, 22);
    chk("rd_done_lat", done_lat, 23);
    chk("rd_no_seqerr", seqerr_cnt, s0);

    // req_valid held high across two frames
    n0 = acc_cnt; f0 = frames;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'b01; req_data = 8'hFF;
    wait_acc(n0 + 1);
    a1 = acc_cyc;
    req_data = 8'h00;
    wait_acc(n0 + 2);
    a2 = acc_cyc;
    req_valid = 1'b0;
    wait_idle();
    chk("busy_spacing", a2 - a1, 14);
    chk("busy_frames", frames - f0, 2);
    chk("busy_mosi_ff", int'(prev_mosi[11:0]), 12'h1FF);
    chk("busy_mosi_00", int'(last_mosi[11:0]), 12'h100);
    chk("busy_rsp_kept", int'(rsp_data), 8'hA5);

    // synchronous reset during SHIFT bit 4
    issue(2'b01, 8'h5A);
    begin
      int t;
      t = 0;
      while (since != 7 && t < 50) begin @(negedge clk); t++; end
    end
    d0 = done_cnt; r0 = rsp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ss_n", int'(SS_n), 1);
    chk("rst_ready", int'(req_ready), 1);
    repeat (2) @(negedge clk);
    chk("rst_no_done", done_cnt, d0);
    chk("rst_no_rsp", rsp_cnt, r0);
    issue(2'b00, 8'h81);
    wait_idle();
    chk("post_rst_done_lat", done_lat, 13);
    chk("post_rst_ss_low", last_ss_low, 12);
    chk("post_rst_rsp_data", int'(rsp_data), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
